// File: rtl/seven_seg_pkg.sv
// Shared widths and digit storage types for the seven-segment scanner.
package seven_seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned SEL_W      = 3;
    localparam int unsigned NIBBLE_W   = 4;

    typedef logic [NIBBLE_W-1:0] digit_t;
    typedef digit_t [NUM_DIGITS-1:0] digit_array_t;

endpackage

// File: rtl/tick_gen.sv
// Slot prescaler: tick is high for the one cycle in which the count sits at TICK_DIV-1.
module tick_gen #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(TICK_DIV - 2);

    logic [CNT_W-1:0] cnt;

    // tick is registered one count early so it lines up with cnt == TICK_DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            tick <= (cnt == CNT_PRE_LAST);
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Eight-digit multiplexed display scanner with a shadow store published atomically at frame boundaries.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [SEL_W-1:0]    wr_addr,
    input  logic [NIBBLE_W-1:0] wr_data,
    input  logic                commit_req,
    output logic [NIBBLE_W-1:0] digit_code,
    output logic [SEL_W-1:0]    sel,
    output logic                frame_done
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

    logic         slot_tick;
    logic         boundary;
    logic         commit_pending;
    digit_array_t shadow;
    digit_array_t active;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (slot_tick)
    );

    // wr_ready is held as the register; a pending commit is simply its inverse
    assign commit_pending = ~wr_ready;
    assign boundary       = slot_tick && (sel == LAST_SEL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel        <= '0;
            frame_done <= 1'b0;
            wr_ready   <= 1'b1;
            shadow     <= '0;
            active     <= '0;
        end else begin
            if (slot_tick) begin
                sel <= sel + SEL_W'(1);
            end
            frame_done <= boundary;

            if (wr_valid && wr_ready) begin
                shadow[wr_addr] <= wr_data;
            end

            // Whole-frame publish; shadow is frozen while pending so the copy is coherent
            if (boundary && commit_pending) begin
                active   <= shadow;
                wr_ready <= 1'b1;
            end else if (commit_req && !commit_pending) begin
                wr_ready <= 1'b0;
            end
        end
    end

    assign digit_code = active[sel];

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (TICK_DIV = 4) against a frame-arithmetic reference model.
module tb_seven_seg_scanner;

    localparam int unsigned TDIV  = 4;
    localparam int unsigned FRAME = 8 * TDIV;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       commit_req;
    logic [3:0] digit_code;
    logic [2:0] sel;
    logic       frame_done;

    seven_seg_scanner #(.TICK_DIV(TDIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit_req (commit_req),
        .digit_code (digit_code),
        .sel        (sel),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: n counts clock edges since reset release; timing follows from n alone
    int         n;
    logic [3:0] m_shadow [8];
    logic [3:0] m_active [8];
    bit         m_pending;
    int         n_checks;
    int         n_pass;
    logic [8:0] got;
    logic [8:0] exp;

    function automatic logic [8:0] expected();
        int s;
        s = (n / TDIV) % 8;
        return {(n > 0) && (n % FRAME == 0), !m_pending, 3'(s), m_active[s]};
    endfunction

    function automatic int model_sel();
        return (n / TDIV) % 8;
    endfunction

    task automatic model_clear();
        n = 0;
        m_pending = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = 4'h0;
            m_active[i] = 4'h0;
        end
    endtask

    // Drive one cycle of inputs, advance model across the edge, return at edge+1
    task automatic step(input bit v, input logic [2:0] a, input logic [3:0] d, input bit c);
        bit boundary;
        bit acc;
        wr_valid   = v;
        wr_addr    = a;
        wr_data    = d;
        commit_req = c;
        @(posedge clk);
        boundary = (n % FRAME) == (FRAME - 1);
        acc      = v && !m_pending;
        if (boundary && m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end else if (c && !m_pending) begin
            m_pending = 1'b1;
        end
        if (acc) m_shadow[a] = d;
        n++;
        #1;
        wr_valid   = 1'b0;
        commit_req = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        wr_valid   = 1'b1;
        wr_addr    = 3'd0;
        wr_data    = 4'hF;
        commit_req = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        got = {frame_done, wr_ready, sel, digit_code};
        exp = expected();
        n_checks++;
        if (got !== exp) $display("FAIL reset_state got=%h exp=%h", got, exp);
        else n_pass++;
        rst        = 1'b0;
        wr_valid   = 1'b0;
        commit_req = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 3'd0, 4'h0, 1'b0);
            got = {frame_done, wr_ready, sel, digit_code};
            exp = expected();
            n_checks++;
            if (got !== exp) $display("FAIL idle_scan cyc=%0d got=%h exp=%h", n, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_write_commit();
        step(1'b1, 3'd3, 4'h9, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 3'd0, 4'h0, 1'b0);
            got = {frame_done, wr_ready, sel, digit_code};
            exp = expected();
            n_checks++;
            if (got !== exp) $display("FAIL write_no_commit cyc=%0d got=%h exp=%h", n, got, exp);
            else n_pass++;
        end
        step(1'b0, 3'd0, 4'h0, 1'b1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 3'd0, 4'h0, 1'b0);
            got = {frame_done, wr_ready, sel, digit_code};
            exp = expected();
            n_checks++;
            if (got !== exp) $display("FAIL write_commit cyc=%0d got=%h exp=%h", n, got, exp);
            else n_pass++;
        end
        for (int i = 0; i < FRAME && model_sel() != 3; i++) step(1'b0, 3'd0, 4'h0, 1'b0);
        n_checks++;
        if (digit_code !== 4'h9) $display("FAIL digit3_shows_9 got=%h exp=9", digit_code);
        else n_pass++;
    endtask

    task automatic test_held_write();
        bit accepted;
        step(1'b0, 3'd0, 4'h0, 1'b1);
        accepted = 1'b0;
        for (int i = 0; i < 3 * FRAME && !accepted; i++) begin
            accepted = wr_ready;
            step(1'b1, 3'd5, 4'hA, 1'b0);
            got = {frame_done, wr_ready, sel, digit_code};
            exp = expected();
            n_checks++;
            if (got !== exp) $display("FAIL held_write cyc=%0d got=%h exp=%h", n, got, exp);
            else n_pass++;
        end
        n_checks++;
        if (!accepted) $display("FAIL held_write_timeout got=0 exp=1");
        else n_pass++;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, 3'd0, 4'h0, 1'b0);
            got = {frame_done, wr_ready, sel, digit_code};
            exp = expected();
            n_checks++;
            if (got !== exp || digit_code === 4'hA)
                $display("FAIL a_absent cyc=%0d got=%h exp=%h", n, got, exp);
            else n_pass++;
        end
        step(1'b0, 3'd0, 4'h0, 1'b1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 3'd0, 4'h0, 1'b0);
            got = {frame_done, wr_ready, sel, digit_code};
            exp = expected();
            n_checks++;
            if (got !== exp) $display("FAIL a_committed cyc=%0d got=%h exp=%h", n, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_commit_at_boundary();
        step(1'b1, 3'd0, 4'h7, 1'b0);
        for (int i = 0; i < FRAME && (n % FRAME) != (FRAME - 1); i++) step(1'b0, 3'd0, 4'h0, 1'b0);
        step(1'b0, 3'd0, 4'h0, 1'b1);
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(1'b0, 3'd0, 4'h0, (i == 10));
            got = {frame_done, wr_ready, sel, digit_code};
            exp = expected();
            n_checks++;
            if (got !== exp) $display("FAIL boundary_commit cyc=%0d got=%h exp=%h", n, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom % 2), 3'($urandom), 4'($urandom), ($urandom % 20) == 0);
            got = {frame_done, wr_ready, sel, digit_code};
            exp = expected();
            n_checks++;
            if (got !== exp) $display("FAIL random cyc=%0d got=%h exp=%h", n, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < FRAME && !m_pending; i++) step(1'b0, 3'd0, 4'h0, 1'b0);
        for (int i = 0; i < 2 * FRAME && m_pending; i++) step(1'b0, 3'd0, 4'h0, 1'b0);
        step(1'b1, 3'd5, 4'hB, 1'b1);
        for (int i = 0; i < 2 * FRAME && m_pending; i++) step(1'b0, 3'd0, 4'h0, 1'b0);
        step(1'b1, 3'd2, 4'hC, 1'b1);
        for (int i = 0; i < FRAME && model_sel() != 5; i++) step(1'b0, 3'd0, 4'h0, 1'b0);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        got = {frame_done, wr_ready, sel, digit_code};
        exp = expected();
        n_checks++;
        if (got !== exp) $display("FAIL async_reset got=%h exp=%h", got, exp);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < FRAME + 4; i++) begin
            step(1'b0, 3'd0, 4'h0, 1'b0);
            got = {frame_done, wr_ready, sel, digit_code};
            exp = expected();
            n_checks++;
            if (got !== exp || digit_code !== 4'h0)
                $display("FAIL post_reset cyc=%0d got=%h exp=%h", n, got, exp);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        wr_valid   = 1'b0;
        wr_addr    = 3'd0;
        wr_data    = 4'h0;
        commit_req = 1'b0;
        test_reset();
        test_idle();
        test_write_commit();
        test_held_write();
        test_commit_at_boundary();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
